// File: rtl/scr1_pipe_ialu_issue_if.sv
// Handshake bundle between the IDU, the IALU, the MPRF writeback port and the IALU issue stage.
// The slave modport is the issue stage's view; the master modport is the surrounding pipeline's view.
interface scr1_pipe_ialu_issue_if #(
    parameter int CMD_W = 5,
    parameter int RD_W  = 5
);
    logic             idu_vd_i;
    logic             idu_rdy_o;
    logic [CMD_W-1:0] idu_cmd_i;
    logic             idu_rvm_i;
    logic [31:0]      idu_op1_i;
    logic [31:0]      idu_op2_i;
    logic [RD_W-1:0]  idu_rd_i;

    logic [CMD_W-1:0] exu2ialu_cmd_o;
    logic [31:0]      exu2ialu_main_op1_o;
    logic [31:0]      exu2ialu_main_op2_o;
    logic             exu2ialu_rvm_cmd_vd_o;
    logic [31:0]      ialu2exu_main_res_i;
    logic             ialu2exu_rvm_res_rdy_i;

    logic             wb_vd_o;
    logic             wb_rdy_i;
    logic [RD_W-1:0]  wb_rd_o;
    logic [31:0]      wb_data_o;

    modport slave (
        input  idu_vd_i, idu_cmd_i, idu_rvm_i, idu_op1_i, idu_op2_i, idu_rd_i,
        output idu_rdy_o,
        output exu2ialu_cmd_o, exu2ialu_main_op1_o, exu2ialu_main_op2_o, exu2ialu_rvm_cmd_vd_o,
        input  ialu2exu_main_res_i, ialu2exu_rvm_res_rdy_i,
        output wb_vd_o, wb_rd_o, wb_data_o,
        input  wb_rdy_i
    );

    modport master (
        output idu_vd_i, idu_cmd_i, idu_rvm_i, idu_op1_i, idu_op2_i, idu_rd_i,
        input  idu_rdy_o,
        input  exu2ialu_cmd_o, exu2ialu_main_op1_o, exu2ialu_main_op2_o, exu2ialu_rvm_cmd_vd_o,
        output ialu2exu_main_res_i, ialu2exu_rvm_res_rdy_i,
        input  wb_vd_o, wb_rd_o, wb_data_o,
        output wb_rdy_i
    );
endinterface

// File: rtl/scr1_pipe_ialu_issue.sv
// IALU issue/hold stage: latches one ALU instruction, holds it on the IALU until done, then writes back.
// Optional performance counters are enabled by defining SCR1_IALU_ISSUE_PERF_EN.
module scr1_pipe_ialu_issue #(
    parameter int CMD_W = 5,
    parameter int RD_W  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    scr1_pipe_ialu_issue_if.slave         io,
    output logic [31:0]                   perf_exec_cyc_o,
    output logic [31:0]                   perf_instr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             rvm_q, rvm_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [31:0]      res_q, res_d;

    logic             idu_rdy;
    logic             accept;
    logic             exec_done;
    logic             in_exec;

    always_comb begin
        in_exec   = (state_q == ST_EXEC);
        idu_rdy   = ~flush_i & ((state_q == ST_IDLE) | ((state_q == ST_WB) & io.wb_rdy_i));
        accept    = io.idu_vd_i & idu_rdy;
        exec_done = in_exec & (~rvm_q | io.ialu2exu_rvm_res_rdy_i);
    end

    // Flush dominates; a result for x0 skips writeback and frees the stage immediately.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rvm_d   = rvm_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        res_d   = res_q;

        if (accept) begin
            cmd_d = io.idu_cmd_i;
            rvm_d = io.idu_rvm_i;
            op1_d = io.idu_op1_i;
            op2_d = io.idu_op2_i;
            rd_d  = io.idu_rd_i;
        end

        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        if (rd_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            res_d   = io.ialu2exu_main_res_i;
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (io.wb_rdy_i) begin
                        state_d = accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            rvm_q   <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rvm_q   <= rvm_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

    // Command is masked outside EXEC so the IALU never sees a stale request.
    assign io.idu_rdy_o             = idu_rdy;
    assign io.exu2ialu_cmd_o        = in_exec ? cmd_q : '0;
    assign io.exu2ialu_main_op1_o   = op1_q;
    assign io.exu2ialu_main_op2_o   = op2_q;
    assign io.exu2ialu_rvm_cmd_vd_o = in_exec & rvm_q & ~flush_i;
    assign io.wb_vd_o               = (state_q == ST_WB);
    assign io.wb_rd_o               = rd_q;
    assign io.wb_data_o             = res_q;

`ifdef SCR1_IALU_ISSUE_PERF_EN
    logic [31:0] perf_exec_q, perf_exec_d;
    logic [31:0] perf_instr_q, perf_instr_d;

    always_comb begin
        perf_exec_d  = perf_exec_q;
        perf_instr_d = perf_instr_q;
        if (in_exec && (perf_exec_q != 32'hFFFF_FFFF)) begin
            perf_exec_d = perf_exec_q + 32'd1;
        end
        if (exec_done && !flush_i && (perf_instr_q != 32'hFFFF_FFFF)) begin
            perf_instr_d = perf_instr_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_exec_q  <= '0;
            perf_instr_q <= '0;
        end else begin
            perf_exec_q  <= perf_exec_d;
            perf_instr_q <= perf_instr_d;
        end
    end

    assign perf_exec_cyc_o = perf_exec_q;
    assign perf_instr_o    = perf_instr_q;
`else
    assign perf_exec_cyc_o = '0;
    assign perf_instr_o    = '0;
`endif

    // An iterative IALU operation relies on its inputs staying frozen until the result is taken.
    hold_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
        (io.exu2ialu_rvm_cmd_vd_o && !io.ialu2exu_rvm_res_rdy_i) |=>
            ($stable(io.exu2ialu_cmd_o) && $stable(io.exu2ialu_main_op1_o) &&
             $stable(io.exu2ialu_main_op2_o)));

endmodule

// File: tb/tb_scr1_pipe_ialu_issue.sv
// Directed bench for scr1_pipe_ialu_issue with a small behavioural IALU (ADD/SUB/DIV).
module tb_scr1_pipe_ialu_issue;

`ifdef SCR1_IALU_ISSUE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] perf_exec_cyc;
    logic [31:0] perf_instr;

    int vectors;
    int miscompares;

    scr1_pipe_ialu_issue_if #(.CMD_W(5), .RD_W(5)) bus ();

    scr1_pipe_ialu_issue #(.CMD_W(5), .RD_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .io              (bus),
        .perf_exec_cyc_o (perf_exec_cyc),
        .perf_instr_o    (perf_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural IALU: divide answers after 34 cycles of a held request, everything else at once.
    int          div_cnt;
    logic [31:0] model_res;
    logic        model_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 0;
        end else if (bus.exu2ialu_rvm_cmd_vd_o && !model_rdy) begin
            div_cnt <= div_cnt + 1;
        end else begin
            div_cnt <= 0;
        end
    end

    always_comb begin
        model_res = 32'd0;
        model_rdy = 1'b1;
        case (bus.exu2ialu_cmd_o)
            5'd4:  model_res = bus.exu2ialu_main_op1_o + bus.exu2ialu_main_op2_o;
            5'd5:  model_res = bus.exu2ialu_main_op1_o - bus.exu2ialu_main_op2_o;
            5'd19: model_res = (bus.exu2ialu_main_op2_o == 32'd0) ? 32'hFFFF_FFFF :
                               bus.exu2ialu_main_op1_o / bus.exu2ialu_main_op2_o;
            default: model_res = 32'd0;
        endcase
        if ((bus.exu2ialu_cmd_o >= 5'd19) && (bus.exu2ialu_cmd_o <= 5'd22)) begin
            model_rdy = (div_cnt == 33);
        end
    end

    assign bus.ialu2exu_main_res_i    = model_res;
    assign bus.ialu2exu_rvm_res_rdy_i = model_rdy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vd, input logic [4:0] cmd, input logic rvm,
                                 input logic [31:0] op1, input logic [31:0] op2,
                                 input logic [4:0] rd);
        bus.idu_vd_i  = vd;
        bus.idu_cmd_i = cmd;
        bus.idu_rvm_i = rvm;
        bus.idu_op1_i = op1;
        bus.idu_op2_i = op2;
        bus.idu_rd_i  = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    int   rvm_cycles;
    logic ops_held;
    logic rdy_while_busy;
    logic wb_seen;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        bus.wb_rdy_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);

        // Reset values
        #12;
        checkOutput("rst_wb_vd",  {31'd0, bus.wb_vd_o}, 32'd0);
        checkOutput("rst_rvm_vd", {31'd0, bus.exu2ialu_rvm_cmd_vd_o}, 32'd0);
        checkOutput("rst_cmd",    {27'd0, bus.exu2ialu_cmd_o}, 32'd0);
        checkOutput("rst_op1",    bus.exu2ialu_main_op1_o, 32'd0);
        checkOutput("rst_op2",    bus.exu2ialu_main_op2_o, 32'd0);
        checkOutput("rst_wb_data", bus.wb_data_o, 32'd0);
        checkOutput("rst_wb_rd",  {27'd0, bus.wb_rd_o}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checkOutput("rst_idu_rdy", {31'd0, bus.idu_rdy_o}, 32'd1);

        // ADD 5+7 -> x3, one EXEC cycle then WB
        applyStimulus(1'b1, 5'd4, 1'b0, 32'd5, 32'd7, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        checkOutput("add_exec_cmd",    {27'd0, bus.exu2ialu_cmd_o}, 32'd4);
        checkOutput("add_exec_rvm_vd", {31'd0, bus.exu2ialu_rvm_cmd_vd_o}, 32'd0);
        checkOutput("add_exec_rdy",    {31'd0, bus.idu_rdy_o}, 32'd0);
        checkOutput("add_exec_wb_vd",  {31'd0, bus.wb_vd_o}, 32'd0);
        bus.wb_rdy_i = 1'b1;
        tick();
        checkOutput("add_wb_vd",   {31'd0, bus.wb_vd_o}, 32'd1);
        checkOutput("add_wb_data", bus.wb_data_o, 32'd12);
        checkOutput("add_wb_rd",   {27'd0, bus.wb_rd_o}, 32'd3);
        checkOutput("add_wb_cmd",  {27'd0, bus.exu2ialu_cmd_o}, 32'd0);
        tick();
        checkOutput("add_idle_wb_vd", {31'd0, bus.wb_vd_o}, 32'd0);

        // DIV 100/7 -> x5, 34-cycle IALU iteration
        bus.wb_rdy_i = 1'b0;
        applyStimulus(1'b1, 5'd19, 1'b1, 32'd100, 32'd7, 5'd5);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        rvm_cycles     = 0;
        ops_held       = 1'b1;
        rdy_while_busy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.wb_vd_o) break;
            if (bus.exu2ialu_rvm_cmd_vd_o) rvm_cycles++;
            if (bus.exu2ialu_main_op1_o != 32'd100 || bus.exu2ialu_main_op2_o != 32'd7 ||
                bus.exu2ialu_cmd_o != 5'd19) ops_held = 1'b0;
            if (bus.idu_rdy_o) rdy_while_busy = 1'b1;
            tick();
        end
        checkOutput("div_wb_vd",      {31'd0, bus.wb_vd_o}, 32'd1);
        checkOutput("div_rvm_cycles", rvm_cycles, 32'd34);
        checkOutput("div_ops_held",   {31'd0, ops_held}, 32'd1);
        checkOutput("div_busy_rdy",   {31'd0, rdy_while_busy}, 32'd0);
        checkOutput("div_wb_data",    bus.wb_data_o, 32'd14);
        checkOutput("div_wb_rd",      {27'd0, bus.wb_rd_o}, 32'd5);
        bus.wb_rdy_i = 1'b1;
        tick();
        checkOutput("div_idle_wb_vd", {31'd0, bus.wb_vd_o}, 32'd0);

        // SUB 1-2 -> x0, result dropped
        applyStimulus(1'b1, 5'd5, 1'b0, 32'd1, 32'd2, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        checkOutput("sub_exec_wb_vd", {31'd0, bus.wb_vd_o}, 32'd0);
        checkOutput("sub_exec_rdy",   {31'd0, bus.idu_rdy_o}, 32'd0);
        tick();
        checkOutput("sub_idle_wb_vd", {31'd0, bus.wb_vd_o}, 32'd0);
        checkOutput("sub_idle_rdy",   {31'd0, bus.idu_rdy_o}, 32'd1);
        checkOutput("perf_instr_3",   perf_instr, PERF_ON ? 32'd3 : 32'd0);
        checkOutput("perf_exec_36",   perf_exec_cyc, PERF_ON ? 32'd36 : 32'd0);

        // Backpressure on ADD 1+1 -> x4, then back-to-back ADD 3+4 -> x6
        bus.wb_rdy_i = 1'b0;
        applyStimulus(1'b1, 5'd4, 1'b0, 32'd1, 32'd1, 5'd4);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_wb_vd",   {31'd0, bus.wb_vd_o}, 32'd1);
            checkOutput("bp_wb_data", bus.wb_data_o, 32'd2);
            checkOutput("bp_rdy",     {31'd0, bus.idu_rdy_o}, 32'd0);
            tick();
        end
        bus.wb_rdy_i = 1'b1;
        applyStimulus(1'b1, 5'd4, 1'b0, 32'd3, 32'd4, 5'd6);
        #1;
        checkOutput("b2b_rdy", {31'd0, bus.idu_rdy_o}, 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        checkOutput("b2b_exec_cmd", {27'd0, bus.exu2ialu_cmd_o}, 32'd4);
        checkOutput("b2b_exec_op1", bus.exu2ialu_main_op1_o, 32'd3);
        checkOutput("b2b_exec_wb_vd", {31'd0, bus.wb_vd_o}, 32'd0);
        tick();
        checkOutput("b2b_wb_vd",   {31'd0, bus.wb_vd_o}, 32'd1);
        checkOutput("b2b_wb_data", bus.wb_data_o, 32'd7);
        checkOutput("b2b_wb_rd",   {27'd0, bus.wb_rd_o}, 32'd6);
        tick();

        // Flush in the tenth EXEC cycle of a DIV
        bus.wb_rdy_i = 1'b0;
        applyStimulus(1'b1, 5'd19, 1'b1, 32'd100, 32'd7, 5'd5);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (9) tick();
        checkOutput("fl_pre_rvm_vd", {31'd0, bus.exu2ialu_rvm_cmd_vd_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        checkOutput("fl_rvm_vd", {31'd0, bus.exu2ialu_rvm_cmd_vd_o}, 32'd0);
        checkOutput("fl_rdy",    {31'd0, bus.idu_rdy_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        checkOutput("fl_idle_cmd", {27'd0, bus.exu2ialu_cmd_o}, 32'd0);
        checkOutput("fl_idle_rdy", {31'd0, bus.idu_rdy_o}, 32'd1);
        wb_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.wb_vd_o) wb_seen = 1'b1;
            tick();
        end
        checkOutput("fl_no_wb", {31'd0, wb_seen}, 32'd0);
        applyStimulus(1'b1, 5'd4, 1'b0, 32'd2, 32'd2, 5'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.wb_rdy_i = 1'b1;
        tick();
        checkOutput("fl_add_wb_vd",   {31'd0, bus.wb_vd_o}, 32'd1);
        checkOutput("fl_add_wb_data", bus.wb_data_o, 32'd4);
        checkOutput("fl_add_wb_rd",   {27'd0, bus.wb_rd_o}, 32'd1);
        tick();
        checkOutput("perf_instr_6", perf_instr, PERF_ON ? 32'd6 : 32'd0);
        checkOutput("perf_exec_49", perf_exec_cyc, PERF_ON ? 32'd49 : 32'd0);

        // Asynchronous reset in the middle of a DIV
        bus.wb_rdy_i = 1'b0;
        applyStimulus(1'b1, 5'd19, 1'b1, 32'd100, 32'd7, 5'd5);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (5) tick();
        checkOutput("mid_rvm_vd", {31'd0, bus.exu2ialu_rvm_cmd_vd_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_rvm_vd",  {31'd0, bus.exu2ialu_rvm_cmd_vd_o}, 32'd0);
        checkOutput("ar_cmd",     {27'd0, bus.exu2ialu_cmd_o}, 32'd0);
        checkOutput("ar_op1",     bus.exu2ialu_main_op1_o, 32'd0);
        checkOutput("ar_op2",     bus.exu2ialu_main_op2_o, 32'd0);
        checkOutput("ar_wb_vd",   {31'd0, bus.wb_vd_o}, 32'd0);
        checkOutput("ar_wb_data", bus.wb_data_o, 32'd0);
        checkOutput("ar_wb_rd",   {27'd0, bus.wb_rd_o}, 32'd0);
        checkOutput("ar_perf_exec",  perf_exec_cyc, 32'd0);
        checkOutput("ar_perf_instr", perf_instr, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        checkOutput("ar_idu_rdy", {31'd0, bus.idu_rdy_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
